// File: rtl/c2h.sv
// c2h: card-to-host return stage; serializes dut2vip into one C2H AXI-S packet.
// Define C2H_CMPT_EN to follow each packet with a completion (CMPT) entry.
module c2h #(
  parameter int DATA_WIDTH        = 256,
  parameter int CRC_WIDTH         = 32,
  parameter int QID_WIDTH         = 11,
  parameter int DUT2VIP_WORDS_NUM = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    ctrl_c2h_start,
  input  logic [QID_WIDTH-1:0]                    ctrl_c2h_qid,
  output logic                                    ctrl_c2h_busy,
  output logic                                    ctrl_c2h_pkt_done,
  input  logic [DATA_WIDTH*DUT2VIP_WORDS_NUM-1:0] dut2vip,
  output logic [DATA_WIDTH-1:0]                   c2h_tdata,
  output logic [CRC_WIDTH-1:0]                    c2h_tcrc,
  output logic [QID_WIDTH-1:0]                    c2h_ctrl_qid,
  output logic [15:0]                             c2h_ctrl_len,
  output logic [5:0]                              c2h_mty,
  output logic                                    c2h_tvalid,
  output logic                                    c2h_tlast,
  input  logic                                    c2h_tready,
  output logic [127:0]                            c2h_cmpt_tdata,
  output logic [QID_WIDTH-1:0]                    c2h_cmpt_qid,
  output logic                                    c2h_cmpt_tvalid,
  input  logic                                    c2h_cmpt_tready
);

  localparam int N  = DUT2VIP_WORDS_NUM;
  localparam int CW = $clog2(N);
  localparam logic [15:0] LEN = 16'(DATA_WIDTH / 8 * N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
`ifdef C2H_CMPT_EN
    ,
    CMPT = 2'd2
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cntr_q, cntr_d;
  logic [QID_WIDTH-1:0]   qid_q, qid_d;
  logic [31:0]            seq_q, seq_d;
  logic                   done_q, done_d;
  logic [DATA_WIDTH-1:0]  words_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cntr_q  <= '0;
      qid_q   <= '0;
      seq_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cntr_q  <= cntr_d;
      qid_q   <= qid_d;
      seq_q   <= seq_d;
      done_q  <= done_d;
    end
  end

  // Payload snapshot; frozen for the whole packet, so no reset needed.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && ctrl_c2h_start) begin
      for (int i = 0; i < N; i++) begin
        words_q[i] <= dut2vip[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cntr_d  = cntr_q;
    qid_d   = qid_q;
    seq_d   = seq_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctrl_c2h_start) begin
          state_d = SEND;
          cntr_d  = CW'(N - 1);
          qid_d   = ctrl_c2h_qid;
        end
      end
      SEND: begin
        if (c2h_tready) begin
          if (cntr_q == '0) begin
`ifdef C2H_CMPT_EN
            state_d = CMPT;
`else
            state_d = IDLE;
            done_d  = 1'b1;
            seq_d   = seq_q + 32'd1;
`endif
          end else begin
            cntr_d = cntr_q - 1'b1;
          end
        end
      end
`ifdef C2H_CMPT_EN
      CMPT: begin
        if (c2h_cmpt_tready) begin
          state_d = IDLE;
          done_d  = 1'b1;
          seq_d   = seq_q + 32'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign ctrl_c2h_busy     = (state_q != IDLE);
  assign ctrl_c2h_pkt_done = done_q;
  assign c2h_tvalid        = (state_q == SEND);
  assign c2h_tlast         = (state_q == SEND) && (cntr_q == '0);
  assign c2h_tdata         = words_q[cntr_q];
  assign c2h_tcrc          = '0;
  assign c2h_ctrl_qid      = qid_q;
  assign c2h_ctrl_len      = LEN;
  assign c2h_mty           = '0;

`ifdef C2H_CMPT_EN
  assign c2h_cmpt_tvalid = (state_q == CMPT);
  assign c2h_cmpt_qid    = qid_q;
  assign c2h_cmpt_tdata  = {80'd0, seq_q, LEN};
`else
  logic unused_cmpt_rdy;
  assign unused_cmpt_rdy = c2h_cmpt_tready;
  assign c2h_cmpt_tvalid = 1'b0;
  assign c2h_cmpt_qid    = '0;
  assign c2h_cmpt_tdata  = '0;
`endif

endmodule

// File: tb/tb_c2h.sv
// tb_c2h: randomized bench for c2h against a queue-based packet model.
// Covers the default build and, when C2H_CMPT_EN is defined, completions.
module tb_c2h;

  localparam int DW  = 256;
  localparam int CRW = 32;
  localparam int QW  = 11;
  localparam int N   = 16;
  localparam int LEN = DW / 8 * N;
  localparam int BUDGET = 400;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [QW-1:0]     qid;
  logic              busy;
  logic              done;
  logic [DW*N-1:0]   bus;
  logic [DW-1:0]     tdata;
  logic [CRW-1:0]    tcrc;
  logic [QW-1:0]     cqid;
  logic [15:0]       clen;
  logic [5:0]        mty;
  logic              tvalid;
  logic              tlast;
  logic              tready;
  logic [127:0]      ctdata;
  logic [QW-1:0]     cmqid;
  logic              ctvalid;
  logic              ctready;

  int total = 0;
  int bad   = 0;
  int seq   = 0;

  always #5 clk = ~clk;

  c2h #(
    .DATA_WIDTH(DW),
    .CRC_WIDTH(CRW),
    .QID_WIDTH(QW),
    .DUT2VIP_WORDS_NUM(N)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ctrl_c2h_start(start),
    .ctrl_c2h_qid(qid),
    .ctrl_c2h_busy(busy),
    .ctrl_c2h_pkt_done(done),
    .dut2vip(bus),
    .c2h_tdata(tdata),
    .c2h_tcrc(tcrc),
    .c2h_ctrl_qid(cqid),
    .c2h_ctrl_len(clen),
    .c2h_mty(mty),
    .c2h_tvalid(tvalid),
    .c2h_tlast(tlast),
    .c2h_tready(tready),
    .c2h_cmpt_tdata(ctdata),
    .c2h_cmpt_qid(cmqid),
    .c2h_cmpt_tvalid(ctvalid),
    .c2h_cmpt_tready(ctready)
  );

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW*N-1:0] rnd_bus();
    logic [DW*N-1:0] r;
    for (int i = 0; i < DW * N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // bp: random tready; mid: extra start in the third SEND cycle
  task automatic run_pkt(input logic [DW*N-1:0] b,
                         input logic [QW-1:0] q,
                         input bit bp,
                         input bit mid);
    logic [DW-1:0] expq [$];
    int cyc = 0;
    for (int i = N - 1; i >= 0; i--) expq.push_back(b[i*DW +: DW]);
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    bus = b; qid = q; start = 1'b1; tready = 1'b0;
    @(negedge clk);
    start = 1'b0; bus = ~b; qid = ~q;
    chk("first_valid", tvalid, 1'b1);
    chk("busy_hi", busy, 1'b1);
    while (expq.size() > 0 && cyc < BUDGET) begin
      chk("valid_hold", tvalid, 1'b1);
      chk("beat_data", tdata, expq[0]);
      chk("beat_last", tlast, expq.size() == 1);
      chk("beat_qid", cqid, q);
      if (mid && cyc == 2) begin
        start = 1'b1; bus = rnd_bus(); qid = QW'($urandom);
      end else begin
        start = 1'b0;
      end
      tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tready) void'(expq.pop_front());
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; tready = 1'b0;
    chk("pkt_budget", cyc < BUDGET, 1'b1);
    if (!bp) chk("pkt_cycles", cyc, N);
    chk("len", clen, LEN);
    chk("tcrc_mty", {tcrc, mty}, '0);
`ifdef C2H_CMPT_EN
    chk("cmpt_done_lo", done, 1'b0);
    for (int k = 0; k < (bp ? 5 : 0); k++) begin
      chk("cmpt_valid", ctvalid, 1'b1);
      chk("cmpt_data", ctdata, {80'd0, 32'(seq), 16'(LEN)});
      chk("cmpt_nodone", done, 1'b0);
      @(negedge clk);
    end
    chk("cmpt_valid", ctvalid, 1'b1);
    chk("cmpt_data", ctdata, {80'd0, 32'(seq), 16'(LEN)});
    chk("cmpt_qid", cmqid, q);
    chk("cmpt_tv_lo", tvalid, 1'b0);
    ctready = 1'b1;
    @(negedge clk);
    ctready = 1'b0;
    chk("cmpt_drop", ctvalid, 1'b0);
`else
    chk("cmpt_off", {ctvalid, cmqid, ctdata}, '0);
`endif
    seq++;
    chk("done_pulse", done, 1'b1);
    chk("busy_lo", busy, 1'b0);
    chk("tvalid_lo", tvalid, 1'b0);
    @(negedge clk);
    chk("done_clear", done, 1'b0);
    chk("no_second", tvalid, 1'b0);
  endtask

  initial begin
    logic [DW*N-1:0] b;
    rst_n = 1'b0; start = 1'b0; qid = '0; bus = '0;
    tready = 1'b0; ctready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", {tvalid, tlast, busy, done, ctvalid}, '0);
    chk("rst_qid", cqid, '0);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) b[i*DW +: DW] = {(DW/32){32'(i)}};
    run_pkt(b, QW'(5), 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) run_pkt(rnd_bus(), QW'($urandom), 1'b1, 1'b0);

    run_pkt(rnd_bus(), QW'($urandom), 1'b0, 1'b1);

    b = rnd_bus();
    @(negedge clk);
    bus = b; qid = QW'(9); start = 1'b1;
    @(negedge clk);
    start = 1'b0; tready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_mid_beat", tdata, b[(N-6)*DW +: DW]);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {tvalid, tlast, busy, done}, '0);
    @(negedge clk);
    tready = 1'b0;
    rst_n = 1'b1;
    seq = 0;
    run_pkt(rnd_bus(), QW'($urandom), 1'b0, 1'b0);

    for (int r = 0; r < 2; r++) run_pkt(rnd_bus(), QW'($urandom), 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c2h.md
# c2h

Card-to-host return stage of the QDMA verification bridge. It captures the DUT result bus on a start pulse and serializes it into a fixed-length C2H AXI-Stream packet of `DUT2VIP_WORDS_NUM` beats toward the QDMA. It optionally follows each packet with a completion (CMPT) entry. It is the counterpart of the H2C deserializer: beat order is chosen so that a loopback `dut2vip = vip2dut` returns the host data in the order it was sent.

## Interface
Parameters:
- `DATA_WIDTH`, 256: C2H beat width in bits.
- `CRC_WIDTH`, 32: width of the `c2h_tcrc` sideband.
- `QID_WIDTH`, 11: queue ID width.
- `DUT2VIP_WORDS_NUM`, 16: number of beats per packet; must be at least 2.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ctrl_c2h_start` in 1: start request. Sampled only in IDLE.
- `ctrl_c2h_qid` in `QID_WIDTH`: destination queue, captured at start.
- `ctrl_c2h_busy` out 1: high in any state other than IDLE.
- `ctrl_c2h_pkt_done` out 1: one-cycle pulse when the packet is finished.
- `dut2vip` in `DATA_WIDTH*DUT2VIP_WORDS_NUM`: result bus, captured at start.
- `c2h_tdata` out `DATA_WIDTH`: beat data.
- `c2h_tcrc` out `CRC_WIDTH`: tied to 0.
- `c2h_ctrl_qid` out `QID_WIDTH`: the captured qid.
- `c2h_ctrl_len` out 16: packet length in bytes, constant `DATA_WIDTH/8*DUT2VIP_WORDS_NUM`.
- `c2h_mty` out 6: tied to 0.
- `c2h_tvalid` out 1: beat valid.
- `c2h_tlast` out 1: marks the last beat.
- `c2h_tready` in 1: QDMA accepts the beat.
- `c2h_cmpt_tdata` out 128: completion entry (macro only).
- `c2h_cmpt_qid` out `QID_WIDTH`: completion queue (macro only).
- `c2h_cmpt_tvalid` out 1: completion valid (macro only).
- `c2h_cmpt_tready` in 1: QDMA accepts the completion (macro only).

## Operation
States:
- **IDLE**
  - If `ctrl_c2h_start`=1: capture `dut2vip` into N word registers and capture `ctrl_c2h_qid`. Load the beat counter with N-1. Go to SEND.
- **SEND**
  - `c2h_tvalid`=1.
  - `c2h_tdata` = word[beat_cntr]. Word i is `dut2vip[(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]`, so the top word is sent first and word 0 last.
  - `c2h_tlast` = (beat_cntr==0).
  - On each handshake (`c2h_tvalid & c2h_tready`) the counter decrements. On the tlast handshake, go to CMPT (macro defined) or IDLE (macro undefined).
- **CMPT**
  - `c2h_cmpt_tvalid`=1. Hold it until `c2h_cmpt_tready`, then go to IDLE.
  - `c2h_cmpt_tdata` layout:
    - [15:0] = `c2h_ctrl_len`
    - [47:16] = pkt_seq, the packet count before increment
    - rest = 0
- **Packet counter (pkt_seq)**
  - 32 bits, increments when a packet finishes, wraps at 2^32 to 0.

Rules:
- AXI-S rules: while `c2h_tvalid`=1, `c2h_tdata`, `c2h_tlast` and qid stay stable until the handshake. `c2h_tvalid` never drops without a handshake.
- `ctrl_c2h_start` is ignored while busy. No queuing, no error flag.
- Captured data is frozen for the whole packet. Changes on `dut2vip` after the start cycle have no effect.
- Reset (any state, including mid-packet):
  - Return to IDLE.
  - `c2h_tvalid`, `c2h_tlast`, `c2h_cmpt_tvalid`, `ctrl_c2h_busy`, `ctrl_c2h_pkt_done` = 0.
  - Beat counter, pkt_seq and captured qid = 0.
  - Data registers need no reset.
  - A partially sent packet is abandoned; no tlast is emitted.

## Timing
- Start sampled in cycle t: `c2h_tvalid`=1 and the first beat appear in t+1. All outputs are registered or derived from state only; there is no combinational path from `c2h_tready` to any output.
- With `c2h_tready` held at 1, the packet takes N consecutive cycles, t+1 .. t+N.
- `ctrl_c2h_pkt_done` pulses in the cycle after the finishing handshake:
  - macro defined: after the cmpt handshake;
  - macro undefined: after the tlast handshake.
- `ctrl_c2h_busy` falls in that same cycle.
- Macro undefined: back-to-back packets have a minimum of one IDLE cycle between the tlast handshake and the next start sample.
- Macro defined: with `c2h_cmpt_tready`=1, CMPT lasts exactly one cycle.

## Configuration
- Macro: `C2H_CMPT_EN`.
- Defined: the CMPT state and completion outputs exist; the done pulse follows the completion handshake.
- Undefined:
  - No CMPT state.
  - `c2h_cmpt_tvalid`=0, `c2h_cmpt_tdata`=0, `c2h_cmpt_qid`=0.
  - `c2h_cmpt_tready` is ignored.
  - Done follows tlast.
  - pkt_seq is still maintained but not observable.

## Test plan
- **Basic packet:** N=16, word i = i replicated across the word, tready=1, start pulse → beats carry words 15..0 in cycles t+1..t+16, tlast only on word 0, `c2h_ctrl_len`=512, done one cycle later.
- **Backpressure:** tready toggles 1,0,0,1… → every beat is held stable while stalled, tvalid never drops, exactly 16 handshakes, the word order is preserved.
- **Ignored start:** start pulsed in the third SEND cycle with a different `dut2vip` → the current packet is unchanged, no second packet follows.
- **Completion (`C2H_CMPT_EN`):** hold cmpt_tready=0 for 5 cycles, run three packets → cmpt_tvalid holds, tdata[47:16] = 0, 1, 2 and [15:0] = 512; done pulses only after each cmpt handshake.
- **Reset mid-packet:** assert rst_n low after beat 5 with tready=1 → tvalid/busy go to 0 asynchronously; the next start sends a full 16-beat packet and pkt_seq restarts at 0.
- **Loopback:** H2C output connected to `dut2vip`, send 16 host beats A0..A15 then start → C2H emits A0..A15 in order.
